// File: rtl/muldiv_sequencer_if.sv
// Request/response and shared-ALU signals of the iterative multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_result;
  logic            alu_carry;

  // Pipeline side: issues requests and owns the ALU that the sequencer borrows.
  modport master (
    output start, flush, op, rs1, rs2, alu_result, alu_carry,
    input  busy, done, result, alu_a, alu_b, alu_control
  );

  // Sequencer side.
  modport slave (
    input  start, flush, op, rs1, rs2, alu_result, alu_carry,
    output busy, done, result, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide controller sequencing the shared ALU over 32 iterations.
module muldiv_sequencer #(
  parameter int unsigned XLEN    = 32,
  parameter logic [3:0]  ALU_ADD = 4'b0000,
  parameter logic [3:0]  ALU_SUB = 4'b1000
) (
  input logic                clk,
  input logic                rst_n,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] lo_q;    // multiplier / dividend-then-quotient
  logic [XLEN-1:0] hi_q;    // product high accumulator / partial remainder
  logic [XLEN-1:0] opb_q;   // multiplicand / divisor magnitude
  logic [5:0]      cnt_q;
  logic            neg_res_q, neg_rem_q;
  logic [XLEN-1:0] result_q;

  logic            busy, done;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [3:0]      alu_control;

  // Operand decode, evaluated from the latched request during PREP.
  logic            is_div, signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign is_div   = op_q[2];
  assign signed_a = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
  assign signed_b = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
  assign sign_a   = signed_a & a_q[XLEN-1];
  assign sign_b   = signed_b & b_q[XLEN-1];
  assign mag_a    = sign_a ? -a_q : a_q;
  assign mag_b    = sign_b ? -b_q : b_q;
  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = is_div && !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign special  = div_zero | div_ovf;
  // op_q[1] separates REM* from DIV*.
  assign special_res = div_zero ? (op_q[1] ? a_q : '1)
                                : (op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // Restoring-divide step: remainder shifted left with the next dividend bit.
  logic [XLEN:0] shifted;
  logic          take;
  assign shifted = {hi_q, lo_q[XLEN-1]};
  assign take    = shifted[XLEN] | bus.alu_carry;

  // Sign fix-up and result select.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_res_q ? -lo_q : lo_q;
  assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

  // Pick the architectural result for the latched funct3.
  always_comb begin
    fix_res = prod_fix[XLEN-1:0];
    unique case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state, status outputs and ALU drive; the ALU is left at add/0/0 unless iterating.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    unique case (state_q)
      StIdle: if (bus.start && !bus.flush) state_d = StPrep;
      StPrep: begin
        busy    = 1'b1;
        state_d = special ? StDone : StIter;
      end
      StIter: begin
        busy = 1'b1;
        if (is_div) begin
          alu_a       = shifted[XLEN-1:0];
          alu_b       = opb_q;
          alu_control = ALU_SUB;
        end else begin
          alu_a = hi_q;
          alu_b = lo_q[0] ? opb_q : '0;
        end
        if (cnt_q == 6'd31) state_d = StFix;
      end
      StFix: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (bus.flush && state_q != StIdle) state_d = StIdle;
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (bus.start && !bus.flush) begin
          op_q <= bus.op;
          a_q  <= bus.rs1;
          b_q  <= bus.rs2;
        end
        StPrep: if (!bus.flush) begin
          neg_res_q <= sign_a ^ sign_b;
          neg_rem_q <= sign_a;
          cnt_q     <= '0;
          hi_q      <= '0;
          lo_q      <= is_div ? mag_a : mag_b;
          opb_q     <= is_div ? mag_b : mag_a;
          if (special) result_q <= special_res;
        end
        StIter: begin
          cnt_q <= cnt_q + 6'd1;
          if (is_div) begin
            hi_q <= take ? bus.alu_result : shifted[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], take};
          end else begin
            {hi_q, lo_q} <= {bus.alu_carry, bus.alu_result, lo_q[XLEN-1:1]};
          end
        end
        StFix: if (!bus.flush) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.result      = result_q;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_control = alu_control;

endmodule
